// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
//   Time-multiplexed scan controller for a NUM_DIGITS-digit common-anode
//   seven-segment display. Drives one shared BCD-to-seven-segment decoder
//   (bcd_out) and the active-low digit anodes. The displayed value lives in
//   a shadow register that only changes at frame boundaries, so a frame never
//   mixes old and new digits. Optional leading-zero blanking and an all-off
//   dead time between digits are supported.
//
// Ports
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   enable            : scanning runs while high
//   blank_lz          : leading-zero blanking enable
//   digits_in, load   : new BCD value (nibble 0 = rightmost) and capture request
//   load_ack          : one-cycle pulse when the captured value goes on display
//   pending           : a captured value is waiting for the next frame boundary
//   bcd_out           : decoder input, 4'hF = blank
//   anode_n           : active-low digit enables
//   digit_idx         : digit currently selected
//   frame_done        : one-cycle pulse as the scan wraps back to digit 0
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int PRESCALE    = 50000,
  parameter int DEAD_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          blank_lz,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic                          load,
  output logic                          load_ack,
  output logic                          pending,
  output logic [3:0]                    bcd_out,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, DWELL, DEAD} scanStateT;

  scanStateT                state, nxtState;
  logic [IDX_W-1:0]         idx, nxtIdx;
  logic [CNT_W-1:0]         cnt, nxtCnt;
  logic [4*NUM_DIGITS-1:0]  shadow, nxtShadow;
  logic [4*NUM_DIGITS-1:0]  pendBuf, nxtPendBuf;
  logic                     nxtPending, nxtAck, nxtFrameDone;
  logic                     advance, wrap;
  logic [NUM_DIGITS-1:0]    zeroAbove;
  logic                     zeroAcc;
  logic [NUM_DIGITS-1:0]    nxtAnode;
  logic [3:0]               nxtBcd;

  assign digit_idx = idx;

  // Next-state, counter and load/commit logic.
  always_comb begin
    nxtState     = state;
    nxtIdx       = idx;
    nxtCnt       = cnt;
    nxtShadow    = shadow;
    nxtPendBuf   = pendBuf;
    nxtPending   = pending;
    nxtAck       = 1'b0;
    nxtFrameDone = 1'b0;
    advance      = 1'b0;
    wrap         = 1'b0;

    if (state == IDLE) begin
      // Nothing is on screen, so any new or waiting value commits at once.
      if (load) begin
        nxtShadow  = digits_in;
        nxtAck     = 1'b1;
        nxtPending = 1'b0;
      end else if (pending) begin
        nxtShadow  = pendBuf;
        nxtAck     = 1'b1;
        nxtPending = 1'b0;
      end
      if (enable) begin
        nxtState = DWELL;
        nxtIdx   = '0;
        nxtCnt   = '0;
      end
    end else if (state == DWELL || state == DEAD) begin
      if (!enable) begin
        nxtState = IDLE;
        nxtIdx   = '0;
        nxtCnt   = '0;
      end else if (state == DWELL) begin
        if (cnt == DWELL_LAST) begin
          nxtCnt = '0;
          if (DEAD_CYCLES > 0) nxtState = DEAD;
          else                 advance  = 1'b1;
        end else begin
          nxtCnt = cnt + 1'b1;
        end
      end else begin
        if (cnt == DEAD_LAST) begin
          nxtCnt   = '0;
          nxtState = DWELL;
          advance  = 1'b1;
        end else begin
          nxtCnt = cnt + 1'b1;
        end
      end

      if (advance) begin
        wrap   = (idx == IDX_LAST);
        nxtIdx = wrap ? '0 : idx + 1'b1;
      end

      // A load on the wrap edge bypasses the buffer; otherwise it waits for
      // the boundary so the current frame keeps showing one consistent value.
      if (wrap) begin
        nxtFrameDone = 1'b1;
        if (load) begin
          nxtShadow  = digits_in;
          nxtAck     = 1'b1;
          nxtPending = 1'b0;
        end else if (pending) begin
          nxtShadow  = pendBuf;
          nxtAck     = 1'b1;
          nxtPending = 1'b0;
        end
      end else if (load) begin
        nxtPendBuf = digits_in;
        nxtPending = 1'b1;
      end
    end else begin
      nxtState = IDLE;
      nxtIdx   = '0;
      nxtCnt   = '0;
    end
  end

  // Display decode works on the next-cycle state and shadow so the anode,
  // BCD and index registers all switch together, including the first digit
  // of a frame that has just picked up a new value.
  always_comb begin
    zeroAcc  = 1'b1;
    zeroAbove = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zeroAcc      = zeroAcc & (nxtShadow[4*k +: 4] == 4'h0);
      zeroAbove[k] = zeroAcc;
    end

    nxtAnode = '1;
    nxtBcd   = 4'hF;
    if (nxtState == DWELL) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (nxtIdx == IDX_W'(k)) begin
          nxtAnode[k] = 1'b0;
          // A blanked digit keeps its anode so every digit gets equal on-time.
          nxtBcd = (blank_lz && k > 0 && zeroAbove[k]) ? 4'hF : nxtShadow[4*k +: 4];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      shadow     <= '0;
      pendBuf    <= '0;
      pending    <= 1'b0;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
      anode_n    <= '1;
      bcd_out    <= 4'hF;
    end else begin
      state      <= nxtState;
      idx        <= nxtIdx;
      cnt        <= nxtCnt;
      shadow     <= nxtShadow;
      pendBuf    <= nxtPendBuf;
      pending    <= nxtPending;
      load_ack   <= nxtAck;
      frame_done <= nxtFrameDone;
      anode_n    <= nxtAnode;
      bcd_out    <= nxtBcd;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl.
//   dut : 4 digits, PRESCALE=4, DEAD_CYCLES=1 -> 20-cycle frame, digit d
//         occupies frame cycles 5d..5d+3, dead time at 5d+4.
//   dut2: 2 digits, PRESCALE=3, DEAD_CYCLES=0 -> 6-cycle frame.
module tb_seven_seg_scan_ctrl;

  logic        clk;
  logic        reset, enable, blank_lz, load;
  logic [15:0] digits_in;
  logic        load_ack, pending, frame_done;
  logic [3:0]  bcd_out;
  logic [3:0]  anode_n;
  logic [1:0]  digit_idx;

  logic        enable2, load2;
  logic [7:0]  digits2;
  logic        loadAck2, pending2, frameDone2;
  logic [3:0]  bcd2;
  logic [1:0]  anode2;
  logic [0:0]  idx2;

  int total = 0;
  int bad   = 0;

  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(4), .DEAD_CYCLES(1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .blank_lz(blank_lz),
    .digits_in(digits_in), .load(load), .load_ack(load_ack), .pending(pending),
    .bcd_out(bcd_out), .anode_n(anode_n), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  seven_seg_scan_ctrl #(.NUM_DIGITS(2), .PRESCALE(3), .DEAD_CYCLES(0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .blank_lz(1'b0),
    .digits_in(digits2), .load(load2), .load_ack(loadAck2), .pending(pending2),
    .bcd_out(bcd2), .anode_n(anode2), .digit_idx(idx2), .frame_done(frameDone2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks dut over frame cycles from..to, ticking after each check.
  // nibs holds what bcd_out must show per digit (F where blanked).
  task automatic span(input int from, input int to, input logic [15:0] nibs,
                      input bit fd0, input bit ack0);
    logic [3:0] eA, eB;
    int d;
    bit dead;
    for (int c = from; c <= to; c++) begin
      d    = c / 5;
      dead = (c % 5) == 4;
      eA   = 4'hF;
      if (!dead) eA[d] = 1'b0;
      eB   = dead ? 4'hF : nibs[4*d +: 4];
      chk($sformatf("anode_n@%0d", c), 16'(anode_n), 16'(eA));
      chk($sformatf("bcd_out@%0d", c), 16'(bcd_out), 16'(eB));
      chk($sformatf("digit_idx@%0d", c), 16'(digit_idx), 16'(d));
      chk($sformatf("frame_done@%0d", c), 16'(frame_done), 16'((c == 0) && fd0));
      chk($sformatf("load_ack@%0d", c), 16'(load_ack), 16'((c == 0) && ack0));
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; blank_lz = 1'b0; load = 1'b0; digits_in = '0;
    enable2 = 1'b0; load2 = 1'b0; digits2 = '0;
    tick(); tick();
    chk("rst anode_n", 16'(anode_n), 16'hF);
    chk("rst bcd_out", 16'(bcd_out), 16'hF);
    chk("rst digit_idx", 16'(digit_idx), 16'h0);
    chk("rst load_ack", 16'(load_ack), 16'h0);
    chk("rst pending", 16'(pending), 16'h0);
    chk("rst frame_done", 16'(frame_done), 16'h0);
    chk("rst2 anode_n", 16'(anode2), 16'h3);
    chk("rst2 bcd_out", 16'(bcd2), 16'hF);

    // Load in IDLE, then start scanning.
    reset = 1'b0; digits_in = 16'h1234; load = 1'b1;
    tick();
    chk("idle load_ack", 16'(load_ack), 16'h1);
    chk("idle anode_n", 16'(anode_n), 16'hF);
    load = 1'b0; enable = 1'b1;
    tick();
    span(0, 19, 16'h1234, 0, 0);

    // Tear-free update during digit 1.
    span(0, 6, 16'h1234, 1, 0);
    load = 1'b1; digits_in = 16'h5678;
    span(7, 7, 16'h1234, 0, 0);
    load = 1'b0;
    chk("tear pending", 16'(pending), 16'h1);
    span(8, 19, 16'h1234, 0, 0);
    chk("tear commit pending", 16'(pending), 16'h0);
    span(0, 19, 16'h5678, 1, 1);

    // Two loads in one frame: last wins, single ack.
    span(0, 2, 16'h5678, 1, 0);
    load = 1'b1; digits_in = 16'h1111;
    span(3, 3, 16'h5678, 0, 0);
    load = 1'b0;
    span(4, 9, 16'h5678, 0, 0);
    load = 1'b1; digits_in = 16'h2222;
    span(10, 10, 16'h5678, 0, 0);
    load = 1'b0;
    chk("dbl pending", 16'(pending), 16'h1);
    span(11, 19, 16'h5678, 0, 0);
    span(0, 18, 16'h2222, 1, 1);

    // Load exactly on the wrap edge commits directly.
    load = 1'b1; digits_in = 16'h0070;
    span(19, 19, 16'h2222, 0, 0);
    load = 1'b0;
    chk("wrap pending", 16'(pending), 16'h0);
    span(0, 18, 16'h0070, 1, 1);

    // Leading-zero blanking, then a zero value.
    blank_lz = 1'b1;
    span(19, 19, 16'h0070, 0, 0);
    span(0, 1, 16'hFF70, 1, 0);
    load = 1'b1; digits_in = 16'h0000;
    span(2, 2, 16'hFF70, 0, 0);
    load = 1'b0;
    span(3, 19, 16'hFF70, 0, 0);
    span(0, 10, 16'hFFF0, 1, 1);

    // Drop enable during digit 2.
    enable = 1'b0;
    tick();
    chk("dis anode_n", 16'(anode_n), 16'hF);
    chk("dis bcd_out", 16'(bcd_out), 16'hF);
    chk("dis digit_idx", 16'(digit_idx), 16'h0);
    chk("dis frame_done", 16'(frame_done), 16'h0);
    tick();
    chk("dis hold anode_n", 16'(anode_n), 16'hF);
    enable = 1'b1;
    tick();
    span(0, 1, 16'hFFF0, 0, 0);
    load = 1'b1; digits_in = 16'h0305;
    span(2, 2, 16'hFFF0, 0, 0);
    load = 1'b0;
    span(3, 19, 16'hFFF0, 0, 0);
    span(0, 2, 16'hF305, 1, 1);

    // Reset with a value pending: discarded, no ack, shadow cleared.
    load = 1'b1; digits_in = 16'h9999;
    tick();
    load = 1'b0;
    chk("pre-rst pending", 16'(pending), 16'h1);
    reset = 1'b1; enable = 1'b0;
    tick();
    chk("mid rst pending", 16'(pending), 16'h0);
    chk("mid rst anode_n", 16'(anode_n), 16'hF);
    chk("mid rst bcd_out", 16'(bcd_out), 16'hF);
    chk("mid rst digit_idx", 16'(digit_idx), 16'h0);
    reset = 1'b0;
    tick();
    chk("post rst load_ack", 16'(load_ack), 16'h0);
    chk("post rst pending", 16'(pending), 16'h0);
    blank_lz = 1'b0; enable = 1'b1;
    tick();
    span(0, 19, 16'h0000, 0, 0);

    // Two digits, no dead time.
    load2 = 1'b1; digits2 = 8'h59;
    tick();
    chk("d2 load_ack", 16'(loadAck2), 16'h1);
    load2 = 1'b0; enable2 = 1'b1;
    tick();
    for (int c = 0; c < 9; c++) begin
      int d;
      logic [1:0] eA;
      logic [3:0] eB;
      d  = (c / 3) % 2;
      eA = (d == 1) ? 2'b01 : 2'b10;
      eB = (d == 1) ? 4'h5 : 4'h9;
      chk($sformatf("d2 anode_n@%0d", c), 16'(anode2), 16'(eA));
      chk($sformatf("d2 bcd_out@%0d", c), 16'(bcd2), 16'(eB));
      chk($sformatf("d2 digit_idx@%0d", c), 16'(idx2), 16'(d));
      chk($sformatf("d2 frame_done@%0d", c), 16'(frameDone2), 16'(c == 6));
      chk($sformatf("d2 pending@%0d", c), 16'(pending2), 16'h0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an NUM_DIGITS-digit common-anode seven-segment display.
- One shared BCD2SevenSegDecoder instance serves all digits. This block drives the decoder's BCD input and the active-low digit anodes.
- Holds a tear-free shadow copy of the displayed value, updated only at frame boundaries.
- Provides optional leading-zero blanking and a dead time between digits to suppress ghosting.

Parameters:
- NUM_DIGITS, 4: number of digits scanned. Range 2..8.
- PRESCALE, 50000: clk cycles each digit is driven (dwell). Must be ≥ 1.
- DEAD_CYCLES, 2: clk cycles with all anodes off between digits. 0 means no dead time.
- CNT_W, 16: width of the dwell/dead counter. Must hold max(PRESCALE, DEAD_CYCLES) - 1.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: scanning on when high.
- blank_lz, input, 1: leading-zero blanking enable.
- digits_in, input, 4*NUM_DIGITS: new BCD value; nibble 0 = rightmost (least significant) digit.
- load, input, 1: request to capture digits_in.
- load_ack, output, 1: one-cycle pulse when the captured value becomes the displayed value.
- pending, output, 1: a captured value is waiting for a frame boundary.
- bcd_out, output, 4: to the decoder's BCDinput. 4'hF means blank; the decoder outputs 7'b0000000.
- anode_n, output, NUM_DIGITS: active-low digit enables.
- digit_idx, output, $clog2(NUM_DIGITS): digit currently selected.
- frame_done, output, 1: one-cycle pulse after the last digit's dead time completes.

Behaviour:
- **Reset values:** state IDLE, anode_n all 1, bcd_out 4'hF, digit_idx 0, counter 0, load_ack 0, pending 0, frame_done 0, shadow register 0, pending buffer 0.
- **All outputs registered.** anode_n, bcd_out and digit_idx change on the same edge.
- **State IDLE:** anodes off, bcd_out F.
  - load → shadow ← digits_in; load_ack pulses the next cycle.
  - enable=1 → DWELL with idx 0, counter 0.
- **State DWELL:** anode_n[idx]=0, others 1. bcd_out = shadow nibble idx, or F if blanked. Digit lasts exactly PRESCALE cycles.
  - If DEAD_CYCLES>0 → DEAD.
  - Else advance idx, staying in DWELL.
- **State DEAD:** anodes all 1, bcd_out F, for DEAD_CYCLES cycles. Then advance idx and return to DWELL.
- **Advance:** idx+1, wrapping from NUM_DIGITS-1 to 0. On wrap:
  - frame_done pulses.
  - Frame boundary commit: if load is asserted that cycle, shadow ← digits_in; else if pending, shadow ← pending buffer. load_ack pulses the next cycle and pending clears.
  - The new value is shown from digit 0 of the next frame.
- **Frame period:** NUM_DIGITS*(PRESCALE+DEAD_CYCLES) cycles.
- **load while scanning, not at a wrap:** pending buffer ← digits_in, pending=1 the next cycle.
  - A repeated load overwrites the buffer (last value wins). Only one load_ack is issued.
  - Displayed digits never mix old and new values within a frame.
- **Leading-zero blanking:** digit k>0 is blanked when blank_lz=1 and shadow nibbles k..NUM_DIGITS-1 are all 0. Digit 0 is never blanked.
  - A blanked digit keeps its anode asserted and its dwell time, with bcd_out=F, so brightness is uniform.
  - Nibbles 10..15 are passed through unmodified; the decoder blanks them.
- **enable drop mid-frame:** next cycle → IDLE, anodes off, idx 0, counter 0. Pending is kept and committed in IDLE.
- **reset mid-operation:** all state returns to reset values. A pending value is discarded; no load_ack.

Test Plan:
- **Basic scan** (PRESCALE=4, DEAD=1, digits_in=16'h1234 loaded in IDLE, then enable=1) → load_ack at cycle+1. anode_n sequence 1110 ×4, 1111 ×1, 1101 ×4, … with bcd_out 4,F,3,F,2,F,1,F. frame_done every 20 cycles.
- **Tear-free update:** load 16'h5678 mid-digit 1 → pending=1. Digits 2 and 3 still show 2,1. At the wrap shadow=5678, load_ack pulses once, next frame shows 8,7,6,5.
- **Double load / simultaneous wrap:** load 16'h1111 then 16'h2222 in the same frame → 2222 displayed, single ack. load asserted exactly on the wrap cycle → that value committed directly.
- **Leading zeros:** shadow 16'h0070, blank_lz=1 → bcd_out 0,7,F,F with anodes still cycling. blank_lz=0 → 0,7,0,0. Shadow 0 → digit 0 shows 0, others F.
- **enable/reset mid-frame:** enable=0 during digit 2 → anodes 1111, bcd_out F the next cycle. Re-enable → scan restarts at idx 0. reset with pending=1 → pending 0, no ack, shadow 0.
- **DEAD_CYCLES=0, NUM_DIGITS=2:** anodes alternate 10/01 every PRESCALE cycles with no all-off gap; idx wraps 1→0.
